// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), all behind start/busy/valid.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             zf,
  output logic             dz
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 zf_q, zf_d;
  logic                 dz_q, dz_d;

  logic [2*WIDTH-1:0]   mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [WIDTH-1:0]     alu_res_s;

  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] f_op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  r = ~(a | b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quot_q   <= {WIDTH{1'b0}};
      dvsr_q   <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      zf_q     <= 1'b1;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
      zf_q     <= zf_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state, datapath iteration and result write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    hi_d     = hi_q;
    zf_d     = zf_q;
    dz_d     = dz_q;

    // Multiplicand shifts left so each multiplier bit adds at its own weight.
    mul_sum_s   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    div_shift_s = {rem_q, quot_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, dvsr_q};
    alu_res_s   = alu_f(op, data1, data2);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, data1};
            mplier_d = data2;
            cnt_d    = CNT_LOAD;
            state_d  = S_MUL;
          end else if (op == OP_DIVU) begin
            if (data2 != {WIDTH{1'b0}}) begin
              rem_d   = {WIDTH{1'b0}};
              quot_d  = data1;
              dvsr_d  = data2;
              cnt_d   = CNT_LOAD;
              state_d = S_DIV;
            end else begin
              valid_d = 1'b1;
              data_d  = {WIDTH{1'b1}};
              hi_d    = data1;
              zf_d    = 1'b0;
              dz_d    = 1'b1;
            end
          end else begin
            valid_d = 1'b1;
            data_d  = alu_res_s;
            hi_d    = {WIDTH{1'b0}};
            zf_d    = (alu_res_s == {WIDTH{1'b0}});
            dz_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = mul_sum_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = mul_sum_s[WIDTH-1:0];
          hi_d    = mul_sum_s[2*WIDTH-1:WIDTH];
          zf_d    = (mul_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
          dz_d    = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        // A borrow out of the trial subtraction means restore (keep the shifted value).
        rem_d  = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = quot_d;
          hi_d    = rem_d;
          zf_d    = (quot_d == {WIDTH{1'b0}});
          dz_d    = 1'b0;
        end else begin
          state_d = S_DIV;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data_out = data_q;
  assign hi_out   = hi_q;
  assign zf       = zf_q;
  assign dz       = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] data1, data2;
  logic         busy, valid, zf, dz;
  logic [W-1:0] data_out, hi_out;

  int checks = 0;
  int errors = 0;
  int k, bc, vcnt;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data1(data1), .data2(data2), .busy(busy), .valid(valid),
    .data_out(data_out), .hi_out(hi_out), .zf(zf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns edges after acceptance until valid, and busy-high cycles seen.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!valid && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("timeout_valid", {63'd0, valid}, 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                           input logic ezf, input logic edz);
    check({tag, "_lo"}, {32'd0, data_out}, {32'd0, lo});
    check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, hi});
    check({tag, "_zf"}, {63'd0, zf}, {63'd0, ezf});
    check({tag, "_dz"}, {63'd0, dz}, {63'd0, edz});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'b0000; data1 = 32'd0; data2 = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_lo", {32'd0, data_out}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_zf", {63'd0, zf}, 64'd1);
    check("rst_dz", {63'd0, dz}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'b0110, 32'd5, 32'd5, k, bc);
    check("sub_lat", 64'(k), 64'd0);
    check("sub_busy_cnt", 64'(bc), 64'd0);
    check_res("sub", 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("sub_valid_pulse", {63'd0, valid}, 64'd0);

    run_op(4'b0111, 32'd1, 32'hFFFF_FFFF, k, bc);
    check("sltu_lat", 64'(k), 64'd0);
    check_res("sltu", 32'd1, 32'd0, 1'b0, 1'b0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, k, bc);
    check_res("add_wrap", 32'd0, 32'd0, 1'b1, 1'b0);
    run_op(4'b1100, 32'd0, 32'd0, k, bc);
    check_res("nor", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(4'b1111, 32'd3, 32'd4, k, bc);
    check_res("bad_op", 32'd0, 32'd0, 1'b1, 1'b0);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, k, bc);
    check_res("and", 32'h0000_F000, 32'd0, 1'b0, 1'b0);
    run_op(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, k, bc);
    check_res("or", 32'h0000_FFF0, 32'd0, 1'b0, 1'b0);

    run_op(4'b1000, 32'd7, 32'd6, k, bc);
    check("mul1_lat", 64'(k), 64'd32);
    check("mul1_busy_cnt", 64'(bc), 64'd32);
    check_res("mul1", 32'd42, 32'd0, 1'b0, 1'b0);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k, bc);
    check("mul2_lat", 64'(k), 64'd32);
    check("mul2_busy_cnt", 64'(bc), 64'd32);
    check_res("mul2", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);

    run_op(4'b1010, 32'd100, 32'd7, k, bc);
    check("div_lat", 64'(k), 64'd32);
    check("div_busy_cnt", 64'(bc), 64'd32);
    check_res("div", 32'd14, 32'd2, 1'b0, 1'b0);
    run_op(4'b1010, 32'd9, 32'd0, k, bc);
    check("divz_lat", 64'(k), 64'd0);
    check("divz_busy_cnt", 64'(bc), 64'd0);
    check_res("divz", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);

    // ADD offered mid-multiply must be ignored.
    op = 4'b1000; data1 = 32'd3; data2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 4'b0010; data1 = 32'd1; data2 = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcnt = 0; k = 0;
    while (!valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (valid) vcnt++;
    check("ign_valid_count", 64'(vcnt), 64'd1);
    check_res("ign_mul", 32'd9, 32'd0, 1'b0, 1'b0);
    run_op(4'b0010, 32'd1, 32'd1, k, bc);
    check("b2b_add_lat", 64'(k), 64'd0);
    check_res("b2b_add", 32'd2, 32'd0, 1'b0, 1'b0);

    // Leave non-reset outputs, then reset in the middle of a divide.
    run_op(4'b1010, 32'd9, 32'd0, k, bc);
    op = 4'b1010; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_valid", {63'd0, valid}, 64'd0);
    check("arst_lo", {32'd0, data_out}, 64'd0);
    check("arst_hi", {32'd0, hi_out}, 64'd0);
    check("arst_zf", {63'd0, zf}, 64'd1);
    check("arst_dz", {63'd0, dz}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("post_rst_valid_count", 64'(vcnt), 64'd0);
    run_op(4'b0010, 32'd2, 32'd3, k, bc);
    check("post_rst_lat", 64'(k), 64'd0);
    check_res("post_rst_add", 32'd5, 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
